// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage initiator.
// Command encoding: bit1 requests a read, bit0 requests a write.
package mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam int         MEM_READ_BIT  = 1;
   localparam int         MEM_WRITE_BIT = 0;
   localparam logic [1:0] WB_BUBBLE     = 2'b00;

   // Exactly one of read/write set is a real access; 11 is illegal, 00 is no access.
   function automatic logic is_mem_cmd(input logic [1:0] cmd);
      return cmd[MEM_READ_BIT] ^ cmd[MEM_WRITE_BIT];
   endfunction

   function automatic logic is_bad_cmd(input logic [1:0] cmd);
      return cmd[MEM_READ_BIT] & cmd[MEM_WRITE_BIT];
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts falling edges spent waiting for the responder; expire_o flags the edge
// on which the count would reach TIMEOUT, so the abort lands on that same edge.
module mem_timeout_counter #(
   parameter  int TIMEOUT = 15,
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic resetN,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)       cnt_d = '0;
      else if (enable_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(negedge clk or negedge resetN) begin
      if (!resetN) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/data_mem_initiator.sv
// MEM-stage initiator: turns EX/MEM load/store commands into a req/ack access to a
// variable-latency data memory, stalls upstream while busy, and registers MEM/WB.
module data_mem_initiator
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [1:0]            writeBackControlIn,
   input  logic [1:0]            memAccessControl,
   input  logic [31:0]           resultIn,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic [4:0]            rdIn,
   output logic                  stall,
   output logic                  memReq,
   output logic                  memWe,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0] memWdata,
   input  logic                  memAck,
   input  logic [DATA_WIDTH-1:0] memRdata,
   output logic [1:0]            writeBackControlOut,
   output logic [DATA_WIDTH-1:0] readData,
   output logic [31:0]           resultOut,
   output logic [4:0]            rdOut,
   output logic                  busError,
   output logic                  cmdError
);

   state_e state_q, state_d;

   logic                  memReq_q, memReq_d;
   logic                  memWe_q, memWe_d;
   logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
   logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
   logic [1:0]            wbc_q, wbc_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [31:0]           res_q, res_d;
   logic [4:0]            rd_q, rd_d;
   logic                  busErr_q, busErr_d;
   logic                  cmdErr_q, cmdErr_d;
   // Writeback fields captured at request time, replayed when the ack arrives.
   logic [1:0]            lwbc_q, lwbc_d;
   logic [31:0]           lres_q, lres_d;
   logic [4:0]            lrd_q, lrd_d;

   logic busy, addr_ok, mem_cmd, legal, illegal, tmo, cnt_en, cnt_clr;

   assign busy    = (state_q == BUSY);
   assign addr_ok = ~|resultIn[31:ADDR_WIDTH];
   assign mem_cmd = is_mem_cmd(memAccessControl);
   assign legal   = mem_cmd && addr_ok;
   assign illegal = is_bad_cmd(memAccessControl) || (mem_cmd && !addr_ok);
   assign cnt_en  = busy && !memAck;
   assign cnt_clr = !busy || memAck;

   mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk      (clk),
      .resetN   (resetN),
      .clear_i  (cnt_clr),
      .enable_i (cnt_en),
      .expire_o (tmo)
   );

   // Held low during reset so a stale command cannot freeze the pipe.
   assign stall = resetN && (busy ? (!memAck && !tmo) : legal);

   always_comb begin
      state_d    = state_q;
      memReq_d   = memReq_q;
      memWe_d    = memWe_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      wbc_d      = wbc_q;
      rdata_d    = rdata_q;
      res_d      = res_q;
      rd_d       = rd_q;
      busErr_d   = busErr_q;
      cmdErr_d   = cmdErr_q;
      lwbc_d     = lwbc_q;
      lres_d     = lres_q;
      lrd_d      = lrd_q;
      case (state_q)
         IDLE: begin
            if (legal) begin
               state_d    = BUSY;
               memReq_d   = 1'b1;
               memWe_d    = memAccessControl[MEM_WRITE_BIT];
               memAddr_d  = resultIn[ADDR_WIDTH-1:0];
               memWdata_d = writeData;
               lwbc_d     = writeBackControlIn;
               lres_d     = resultIn;
               lrd_d      = rdIn;
               wbc_d      = WB_BUBBLE;
            end else if (illegal) begin
               cmdErr_d = 1'b1;
               wbc_d    = WB_BUBBLE;
               rdata_d  = '0;
            end else begin
               wbc_d   = writeBackControlIn;
               rdata_d = '0;
               res_d   = resultIn;
               rd_d    = rdIn;
            end
         end
         BUSY: begin
            // Ack beats timeout when both land on the same edge.
            if (memAck) begin
               state_d  = IDLE;
               memReq_d = 1'b0;
               wbc_d    = lwbc_q;
               res_d    = lres_q;
               rd_d     = lrd_q;
               rdata_d  = memWe_q ? '0 : memRdata;
            end else if (tmo) begin
               state_d  = IDLE;
               memReq_d = 1'b0;
               busErr_d = 1'b1;
               wbc_d    = WB_BUBBLE;
               rdata_d  = '0;
            end else begin
               wbc_d = WB_BUBBLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge resetN) begin
      if (!resetN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(negedge clk or negedge resetN) begin
      if (!resetN) begin
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         wbc_q      <= '0;
         rdata_q    <= '0;
         res_q      <= '0;
         rd_q       <= '0;
         busErr_q   <= 1'b0;
         cmdErr_q   <= 1'b0;
         lwbc_q     <= '0;
         lres_q     <= '0;
         lrd_q      <= '0;
      end else begin
         memReq_q   <= memReq_d;
         memWe_q    <= memWe_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
         wbc_q      <= wbc_d;
         rdata_q    <= rdata_d;
         res_q      <= res_d;
         rd_q       <= rd_d;
         busErr_q   <= busErr_d;
         cmdErr_q   <= cmdErr_d;
         lwbc_q     <= lwbc_d;
         lres_q     <= lres_d;
         lrd_q      <= lrd_d;
      end
   end

   assign memReq              = memReq_q;
   assign memWe               = memWe_q;
   assign memAddr             = memAddr_q;
   assign memWdata            = memWdata_q;
   assign writeBackControlOut = wbc_q;
   assign readData            = rdata_q;
   assign resultOut           = res_q;
   assign rdOut               = rd_q;
   assign busError            = busErr_q;
   assign cmdError            = cmdErr_q;

endmodule

// File: doc/data_mem_initiator.md
# data_mem_initiator

Memory-stage initiator for the pipelined datapath: takes the EX/MEM load/store command and drives a request/acknowledge handshake to an external, variable-latency data-memory responder. It stalls the upstream pipeline while an access is outstanding. It registers the MEM/WB outputs: write-back control, read data, ALU result and destination register. It also provides timeout, illegal-command and address-range checks with sticky error flags.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 10, word-address width of the data memory (1024 words)
- TIMEOUT, 15, falling edges in BUSY without memAck before the access is aborted

Ports:
- clk  in  1  single clock; all state updates on the falling edge
- resetN  in  1  asynchronous, active-low reset
- writeBackControlIn  in  2  write-back control from EX/MEM
- memAccessControl  in  2  bit1 = read, bit0 = write
- resultIn  in  32  ALU result; word address for loads/stores
- writeData  in  DATA_WIDTH  store data
- rdIn  in  5  destination register
- stall  out  1  combinational; upstream stages hold when 1
- memReq  out  1  request to memory responder
- memWe  out  1  1 = write, 0 = read; valid while memReq
- memAddr  out  ADDR_WIDTH  word address; valid while memReq
- memWdata  out  DATA_WIDTH  store data; valid while memReq
- memAck  in  1  responder done; memRdata valid in the same cycle
- memRdata  in  DATA_WIDTH  read data
- writeBackControlOut  out  2  registered to WB
- readData  out  DATA_WIDTH  registered to WB
- resultOut  out  32  registered to WB
- rdOut  out  5  registered to WB
- busError  out  1  sticky: an access timed out
- cmdError  out  1  sticky: illegal command or out-of-range address

## Operation
- States: IDLE, BUSY.
- IDLE, memAccessControl = 00: pass-through. On the edge, the four WB outputs load their inputs; readData loads 0.
- IDLE, command 10 or 01 with resultIn < 2^ADDR_WIDTH:
  - stall = 1 combinationally before the edge.
  - On the edge: latch the command; memReq = 1; memWe = bit0; memAddr = resultIn[ADDR_WIDTH-1:0]; memWdata = writeData.
  - Go to BUSY. Emit a bubble: writeBackControlOut = 0; other WB outputs hold.
- IDLE, command 11 or address out of range:
  - No request; cmdError set; stall = 0.
  - On the edge: bubble out (writeBackControlOut = 0, readData = 0).
- BUSY: memReq, memWe, memAddr and memWdata stay stable until the access ends.
  - stall = !memAck.
  - Each edge without ack increments the timeout counter and emits a bubble.
- BUSY, memAck sampled 1:
  - memReq = 0; counter cleared; return to IDLE.
  - WB outputs load the latched rd, resultIn and writeBackControl.
  - readData = memRdata for a read, 0 for a write.
- BUSY, counter reaches TIMEOUT without ack:
  - memReq = 0; busError set; return to IDLE; stall = 0 for that cycle.
  - WB outputs: writeBackControlOut = 0, readData = 0.
- Ack and timeout on the same edge: ack wins, normal completion, no error.
- Error flags clear only on reset.

## Timing
- Reset (async, immediate) values:
  - memReq, memWe, stall-driving state, busError, cmdError = 0
  - memAddr, memWdata, all WB outputs = 0
  - state = IDLE, counter = 0
- Reset mid-BUSY drops memReq without waiting for ack. A late memAck after reset is ignored in IDLE.
- Non-memory op: 1 edge to WB outputs, no stall.
- Memory op:
  - Request registered at edge N.
  - Earliest ack sampled at edge N+1; WB outputs valid after N+1.
  - Upstream stalled for (ack edge − N) cycles; minimum 1.
- memAck outside BUSY is ignored.

## Structure
- Shared package `mem_pkg`:
  - state enum {IDLE, BUSY}
  - MEM_READ_BIT = 1, MEM_WRITE_BIT = 0
  - WB_BUBBLE = 2'b00
- Sub-module `mem_timeout_counter`: clear, enable, terminal-count output at TIMEOUT, async active-low reset.

## Test plan
- Reset, then command 00, resultIn = 0x1234, rdIn = 7, writeBackControlIn = 2'b10 → next edge: resultOut = 0x1234, rdOut = 7, writeBackControlOut = 2'b10, readData = 0; stall never 1.
- Read (command 10), resultIn = 3, responder acks 2 cycles after memReq with 0xCAFEF00D → memAddr = 3, memWe = 0; stall high for exactly 2 cycles; bubbles meanwhile; then readData = 0xCAFEF00D with the latched rd.
- Write (command 01), resultIn = 5, writeData = 0xA5A5A5A5, immediate ack → memWe = 1, memWdata stable until ack; one stall cycle; readData = 0.
- Command 11, then separately resultIn = 1024 → no memReq; cmdError = 1 and stays 1; WB outputs show a bubble.
- Read with ack never given → memReq drops after TIMEOUT = 15 BUSY edges; busError = 1; stall released. Repeat with ack on edge 15 → normal completion, no busError.
- resetN low while BUSY → memReq, stall and all outputs go to 0 immediately, state IDLE; subsequent memAck ignored.
